// File: rtl/tsc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tsc_pkg                                                |
// | Description : Shared types and helpers for the trigger surround cache|
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package tsc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4,
        SEND  = 3'd5
    } tsc_state_t;

    localparam logic TRIG_RISING  = 1'b0;
    localparam logic TRIG_FALLING = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage : tsc_pkg
`default_nettype wire

// File: rtl/tsc_ring_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tsc_ring_buffer                                        |
// | Description : DEPTH x DW simple dual-port RAM, registered read port  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tsc_ring_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule : tsc_ring_buffer
`default_nettype wire

// File: rtl/tsc_cache_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tsc_cache_param                                        |
// | Description : Trigger surround cache: ring capture, threshold trigger|
// |               and four-phase req/rdy readout of the frozen window    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tsc_cache_param
    import tsc_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int PRE   = 4,
    parameter int TW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] adc_data,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_mode,
    input  logic          sbf,
    input  logic          req,
    output logic          rdy,
    output logic [DW-1:0] dat,
    output logic          trd,
    output logic          cd,
    output logic [TW-1:0] trigtm,
    output logic          sd
);

    localparam int             c_AW        = clog2(DEPTH);
    localparam logic [c_AW-1:0] c_PRE       = c_AW'(PRE);
    localparam logic [c_AW-1:0] c_PRE_M1    = c_AW'(PRE - 1);
    localparam logic [c_AW-1:0] c_POST_LOAD = c_AW'(DEPTH - PRE - 1);
    localparam logic [c_AW-1:0] c_LAST      = c_AW'(DEPTH - 1);

    tsc_state_t      r_state;
    logic [TW-1:0]   r_ts;
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_tptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW-1:0] r_fill_cnt;
    logic [c_AW-1:0] r_post_cnt;
    logic [c_AW-1:0] r_send_cnt;
    logic [DW-1:0]   r_prev;

    logic            w_wr_en;
    logic            w_trig;
    logic [c_AW-1:0] w_rptr_nxt;
    logic [DW-1:0]   w_rd_data;

    assign w_wr_en = (r_state == FILL) || (r_state == ARMED) || (r_state == POST);

    always_comb begin
        w_trig = 1'b0;
        if (trig_mode == TRIG_RISING)
            w_trig = (r_prev < trig_level) && (adc_data >= trig_level);
        else
            w_trig = (r_prev > trig_level) && (adc_data <= trig_level);
    end

    // The RAM is addressed with the pointer's next value so its registered
    // output already holds mem[rptr] whenever the handshake needs it.
    always_comb begin
        w_rptr_nxt = r_rptr;
        if (r_state == DONE && sbf)
            w_rptr_nxt = r_tptr - c_PRE;
        else if (r_state == SEND && rdy && !req)
            w_rptr_nxt = r_rptr + 1'b1;
    end

    tsc_ring_buffer #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_ring (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wptr),
        .i_wr_data (adc_data),
        .i_rd_addr (w_rptr_nxt),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ts       <= '0;
            r_wptr     <= '0;
            r_tptr     <= '0;
            r_rptr     <= '0;
            r_fill_cnt <= '0;
            r_post_cnt <= '0;
            r_send_cnt <= '0;
            r_prev     <= '0;
            rdy        <= 1'b0;
            dat        <= '0;
            trd        <= 1'b0;
            cd         <= 1'b0;
            trigtm     <= '0;
            sd         <= 1'b0;
        end else begin
            if (r_state != IDLE)
                r_ts <= r_ts + 1'b1;
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
                r_prev <= adc_data;
            end
            r_rptr <= w_rptr_nxt;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        trd        <= 1'b0;
                        sd         <= 1'b0;
                        r_wptr     <= '0;
                        r_fill_cnt <= '0;
                        r_ts       <= '0;
                        r_state    <= FILL;
                    end
                end
                FILL: begin
                    if (r_fill_cnt == c_PRE_M1)
                        r_state <= ARMED;
                    else
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                end
                ARMED: begin
                    if (w_trig) begin
                        trigtm     <= r_ts;
                        r_tptr     <= r_wptr;
                        trd        <= 1'b1;
                        r_post_cnt <= c_POST_LOAD;
                        if (c_POST_LOAD == '0) begin
                            cd      <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= POST;
                        end
                    end
                end
                POST: begin
                    r_post_cnt <= r_post_cnt - 1'b1;
                    if (r_post_cnt == c_AW'(1)) begin
                        cd      <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (sbf) begin
                        r_send_cnt <= '0;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    if (req && !rdy) begin
                        rdy <= 1'b1;
                        dat <= w_rd_data;
                    end else if (!req && rdy) begin
                        rdy        <= 1'b0;
                        r_send_cnt <= r_send_cnt + 1'b1;
                        if (r_send_cnt == c_LAST) begin
                            sd      <= 1'b1;
                            cd      <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : tsc_cache_param
`default_nettype wire
